// File: rtl/wb_dma_arbiter.sv
// Two-master round-robin arbiter in front of the pipelined Wishbone DMA slave port.
// Optional no-ack watchdog: define WB_ARB_TIMEOUT_EN.
module wb_dma_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic        ext_clk,
  input  logic        ext_rst_n,
  input  logic [29:0] m0_adr,
  input  logic [31:0] m0_dat_w,
  input  logic [3:0]  m0_sel,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  output logic [31:0] m0_dat_r,
  output logic        m0_ack,
  output logic        m0_stall,
  input  logic [29:0] m1_adr,
  input  logic [31:0] m1_dat_w,
  input  logic [3:0]  m1_sel,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  output logic [31:0] m1_dat_r,
  output logic        m1_ack,
  output logic        m1_stall,
  output logic [29:0] s_adr,
  output logic [31:0] s_dat_w,
  output logic [3:0]  s_sel,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  input  logic [31:0] s_dat_r,
  input  logic        s_ack,
  input  logic        s_stall,
  output logic        timeout_flag
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] out_q, out_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          last_q, last_d;

  logic owned, own_cyc, own_stb, other_cyc, burst_full, cap, accept, dec, to_hit;

  // Owner-relative view of the request lines
  assign owned      = (state_q != IDLE);
  assign own_cyc    = (state_q == OWN1) ? m1_cyc : m0_cyc;
  assign own_stb    = (state_q == OWN1) ? m1_stb : m0_stb;
  assign other_cyc  = (state_q == OWN1) ? m0_cyc : m1_cyc;
  assign burst_full = (burst_q == BW'(MAX_BURST));
  assign cap        = (out_q == OW'(MAX_OUTSTANDING)) || (burst_full && other_cyc);
  assign accept     = owned && own_stb && !cap && !s_stall;
  assign dec        = owned && (s_ack || to_hit) && (out_q != '0);

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    burst_d  = burst_q;
    last_d   = last_q;
    s_adr    = '0;
    s_dat_w  = '0;
    s_sel    = '0;
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    m0_dat_r = '0;
    m0_ack   = 1'b0;
    m0_stall = 1'b1;
    m1_dat_r = '0;
    m1_ack   = 1'b0;
    m1_stall = 1'b1;

    case (state_q)
      OWN0: begin
        s_adr    = m0_adr;
        s_dat_w  = m0_dat_w;
        s_sel    = m0_sel;
        s_we     = m0_we;
        s_cyc    = m0_cyc;
        s_stb    = m0_stb && !cap;
        m0_ack   = s_ack || to_hit;
        m0_dat_r = to_hit ? TIMEOUT_DATA : s_dat_r;
        m0_stall = s_stall || cap;
      end
      OWN1: begin
        s_adr    = m1_adr;
        s_dat_w  = m1_dat_w;
        s_sel    = m1_sel;
        s_we     = m1_we;
        s_cyc    = m1_cyc;
        s_stb    = m1_stb && !cap;
        m1_ack   = s_ack || to_hit;
        m1_dat_r = to_hit ? TIMEOUT_DATA : s_dat_r;
        m1_stall = s_stall || cap;
      end
      default: ;
    endcase

    // Grant on the registered state; ties go to the master that did not own last
    if (state_q == IDLE) begin
      out_d = '0;
      if (m0_cyc && (!m1_cyc || last_q)) begin
        state_d = OWN0;
        last_d  = 1'b0;
        burst_d = '0;
      end else if (m1_cyc) begin
        state_d = OWN1;
        last_d  = 1'b1;
        burst_d = '0;
      end
    end else if (!own_cyc) begin
      state_d = IDLE;
      out_d   = '0;
    end else if (burst_full && other_cyc && (out_q == '0)) begin
      state_d = IDLE;
    end else begin
      if (accept && !dec) begin
        out_d = out_q + OW'(1);
      end else if (!accept && dec) begin
        out_d = out_q - OW'(1);
      end
      if (accept && !burst_full) begin
        burst_d = burst_q + BW'(1);
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q;
  logic          flag_q;

  // Watchdog fabricates an ack when the slave goes silent with work outstanding
  assign to_hit = owned && own_cyc && (out_q != '0) && !s_ack && (to_cnt_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      to_cnt_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      if (!owned || s_ack || (out_q == '0) || to_hit) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end
      if (to_hit) begin
        flag_q <= 1'b1;
      end
    end
  end

  assign timeout_flag = flag_q;
`else
  assign to_hit       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Directed self-checking bench for wb_dma_arbiter: reset, tie-break, pipelining,
// burst-cap handover, abandon, and the no-ack watchdog (both build flavours).
module tb_wb_dma_arbiter;

  logic        ext_clk;
  logic        ext_rst_n;
  logic [29:0] m0_adr, m1_adr, s_adr;
  logic [31:0] m0_dat_w, m1_dat_w, s_dat_w;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_dat_r, m1_dat_r, s_dat_r;
  logic        m0_ack, m0_stall, m1_ack, m1_stall;
  logic        s_cyc, s_stb, s_we, s_ack, s_stall;
  logic        timeout_flag;

  logic        auto_en, man_ack;
  logic [3:0]  pipe;

  int n_assert = 0;
  int n_fail   = 0;
  int acc, acks, n;
  logic a, got_grant1;

  wb_dma_arbiter dut (
    .ext_clk(ext_clk), .ext_rst_n(ext_rst_n),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
    .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
    .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_stall(m1_stall),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_stall(s_stall),
    .timeout_flag(timeout_flag)
  );

  initial ext_clk = 1'b0;
  always #5 ext_clk = ~ext_clk;

  // Auto slave: acks each accepted strobe on the fourth edge after acceptance
  always @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) pipe <= '0;
    else            pipe <= {pipe[2:0], auto_en & s_cyc & s_stb & ~s_stall};
  end
  assign s_ack = auto_en ? pipe[3] : man_ack;

  task automatic tick();
    @(posedge ext_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    ext_rst_n = 1'b0;
    m0_adr = '0; m0_dat_w = '0; m0_sel = '0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    m1_adr = '0; m1_dat_w = '0; m1_sel = '0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    s_dat_r = '0; s_stall = 1'b0; man_ack = 1'b0; auto_en = 1'b0;

    // 1: reset values, single read, async reset mid-transfer
    tick(); tick();
    chk("rst m0_stall", 32'(m0_stall), 32'd1);
    chk("rst m1_stall", 32'(m1_stall), 32'd1);
    chk("rst s_cyc", 32'(s_cyc), 32'd0);
    chk("rst timeout_flag", 32'(timeout_flag), 32'd0);
    man_ack = 1'b1; #1;
    chk("rst m0_ack discarded", 32'(m0_ack), 32'd0);
    chk("rst m1_ack discarded", 32'(m1_ack), 32'd0);
    man_ack = 1'b0;
    ext_rst_n = 1'b1;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 30'h10; m0_sel = 4'hF; #1;
    chk("t1 idle m0_stall", 32'(m0_stall), 32'd1);
    chk("t1 idle s_cyc", 32'(s_cyc), 32'd0);
    tick();
    chk("t1 own0 s_cyc", 32'(s_cyc), 32'd1);
    chk("t1 own0 s_stb", 32'(s_stb), 32'd1);
    chk("t1 own0 s_adr", 32'(s_adr), 32'h10);
    chk("t1 own0 m0_stall", 32'(m0_stall), 32'd0);
    chk("t1 own0 m1_stall", 32'(m1_stall), 32'd1);
    tick();
    m0_stb = 1'b0; s_dat_r = 32'h1234_5678; man_ack = 1'b1; #1;
    chk("t1 m0_ack", 32'(m0_ack), 32'd1);
    chk("t1 m0_dat_r", m0_dat_r, 32'h1234_5678);
    chk("t1 m1_dat_r", m1_dat_r, 32'h0);
    chk("t1 m1_ack", 32'(m1_ack), 32'd0);
    tick();
    man_ack = 1'b0;
    ext_rst_n = 1'b0; #1;
    chk("t1 async rst s_cyc", 32'(s_cyc), 32'd0);
    chk("t1 async rst m0_stall", 32'(m0_stall), 32'd1);
    m0_cyc = 1'b0;
    tick();
    ext_rst_n = 1'b1;
    tick();

    // 2: tie-break alternation
    m0_cyc = 1'b1; m1_cyc = 1'b1; #1;
    chk("t2 idle m0_stall", 32'(m0_stall), 32'd1);
    chk("t2 idle m1_stall", 32'(m1_stall), 32'd1);
    tick();
    chk("t2 tie1 m0_stall", 32'(m0_stall), 32'd0);
    chk("t2 tie1 m1_stall", 32'(m1_stall), 32'd1);
    m0_cyc = 1'b0; #1;
    chk("t2 drop s_cyc", 32'(s_cyc), 32'd0);
    tick();
    chk("t2 idle gap m1_stall", 32'(m1_stall), 32'd1);
    tick();
    chk("t2 own1 m1_stall", 32'(m1_stall), 32'd0);
    chk("t2 own1 m0_stall", 32'(m0_stall), 32'd1);
    m1_cyc = 1'b0; #1;
    tick();
    m0_cyc = 1'b1; m1_cyc = 1'b1; #1;
    tick();
    chk("t2 tie2 m0_stall", 32'(m0_stall), 32'd0);
    chk("t2 tie2 m1_stall", 32'(m1_stall), 32'd1);
    m0_cyc = 1'b0; m1_cyc = 1'b0; #1;
    tick();

    // 3: m1 pipelines 6 strobes against a 4-deep outstanding limit
    auto_en = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 30'h200; #1;
    tick(); #1;
    acc = 0; acks = 0;
    for (int i = 0; i < 60 && !(acc == 6 && acks == 6); i++) begin
      if (m1_ack) acks++;
      a = m1_stb && !m1_stall;
      tick();
      if (a) begin
        acc++;
        if (acc == 4) chk("t3 stall after 4th accept", 32'(m1_stall), 32'd1);
        if (acc == 6) m1_stb = 1'b0;
      end
      #1;
    end
    chk("t3 accepts", 32'(acc), 32'd6);
    chk("t3 outstanding drained", 32'(dut.out_q), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (m1_ack) acks++;
      tick();
    end
    chk("t3 acks", 32'(acks), 32'd6);
    m1_cyc = 1'b0; #1;
    tick();

    // 4: burst cap forces handover to m1, then m0 resumes
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_dat_w = 32'hA5A5_0000; #1;
    tick();
    m1_cyc = 1'b1; #1;
    acc = 0; acks = 0; got_grant1 = 1'b0;
    for (int i = 0; i < 400 && !(acc == 40 && acks == 40); i++) begin
      if (m0_ack) acks++;
      if (m1_cyc && !m1_stall && !got_grant1) begin
        got_grant1 = 1'b1;
        chk("t4 accepts at handover", 32'(acc), 32'd16);
        chk("t4 acks drained at handover", 32'(acks), 32'd16);
        chk("t4 m0 stalled while m1 owns", 32'(m0_stall), 32'd1);
        m1_cyc = 1'b0;
      end
      a = m0_stb && !m0_stall;
      tick();
      if (a) begin
        acc++;
        m0_adr = 30'(acc);
        if (acc == 16) chk("t4 cap stall", 32'(m0_stall), 32'd1);
        if (acc == 40) m0_stb = 1'b0;
      end
      #1;
    end
    chk("t4 m1 granted", 32'(got_grant1), 32'd1);
    chk("t4 total accepts", 32'(acc), 32'd40);
    chk("t4 total acks", 32'(acks), 32'd40);
    m0_cyc = 1'b0; m0_we = 1'b0; #1;
    tick();
    auto_en = 1'b0;

    // 5: accept+ack same cycle, then abandon with 2 outstanding
    m0_cyc = 1'b1; #1;
    tick();
    m0_stb = 1'b1; #1;
    tick();
    tick();
    man_ack = 1'b1; #1;
    chk("t5 ack forwarded", 32'(m0_ack), 32'd1);
    tick();
    m0_stb = 1'b0; man_ack = 1'b0; #1;
    chk("t5 count held", 32'(dut.out_q), 32'd2);
    m0_cyc = 1'b0; #1;
    tick();
    chk("t5 abandon clears count", 32'(dut.out_q), 32'd0);
    chk("t5 idle m0_stall", 32'(m0_stall), 32'd1);
    man_ack = 1'b1; #1;
    chk("t5 late ack m0", 32'(m0_ack), 32'd0);
    chk("t5 late ack m1", 32'(m1_ack), 32'd0);
    tick();
    chk("t5 count after late ack", 32'(dut.out_q), 32'd0);
    man_ack = 1'b0;

    // 6: slave never acks
    m0_cyc = 1'b1; m0_stb = 1'b1; s_dat_r = 32'h5555_AAAA; #1;
    tick();
    m1_cyc = 1'b1; #1;
    tick();
    m0_stb = 1'b0;
    n = 0;
    while (!m0_ack && n < 1100) begin
      tick();
      n++;
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("t6 timeout cycles", 32'(n), 32'd1024);
    chk("t6 synthetic ack", 32'(m0_ack), 32'd1);
    chk("t6 synthetic data", m0_dat_r, 32'hDEAD_BEEF);
    tick();
    chk("t6 timeout_flag", 32'(timeout_flag), 32'd1);
    chk("t6 m1 still stalled", 32'(m1_stall), 32'd1);
`else
    chk("t6 no ack seen", 32'(n), 32'd1100);
    chk("t6 timeout_flag", 32'(timeout_flag), 32'd0);
    chk("t6 grant held m1_stall", 32'(m1_stall), 32'd1);
    chk("t6 grant held m0_stall", 32'(m0_stall), 32'd0);
`endif
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
